// File: rtl/pipe_column_gen.sv
// Pipe-column generator: LFSR-driven gap placement with a reachable vertical step,
// valid/ack handoff to the playfield, and a gap that shrinks as difficulty rises.
module pipe_column_gen #(
   parameter int unsigned ROWS        = 16,
   parameter int unsigned GAP_INIT    = 5,
   parameter int unsigned GAP_MIN     = 3,
   parameter int unsigned MAX_STEP    = 3,
   parameter int unsigned LEVEL_PIPES = 8,
   parameter int unsigned MAX_TRIES   = 8,
   parameter logic [7:0]  SEED        = 8'hA5,
   localparam int unsigned CW         = $clog2(ROWS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            restart_i,
   input  logic            req_i,
   input  logic            col_ack_i,
   output logic            col_valid_o,
   output logic [ROWS-1:0] col_o,
   output logic [CW-1:0]   gap_top_o,
   output logic [CW-1:0]   gap_size_o,
   output logic [3:0]      level_o,
   output logic            busy_o
);

   localparam int unsigned TW       = $clog2(MAX_TRIES + 1);
   localparam int unsigned PW       = $clog2(LEVEL_PIPES + 1);
   localparam int unsigned StepLim  = (MAX_STEP > ROWS) ? ROWS : MAX_STEP;

   localparam logic [CW-1:0] TopInit   = CW'((ROWS - GAP_INIT) / 2);
   localparam logic [CW-1:0] GapInit   = CW'(GAP_INIT);
   localparam logic [CW-1:0] GapMin    = CW'(GAP_MIN);
   localparam logic [CW:0]   RowsM1    = (CW+1)'(ROWS - 1);
   localparam logic [CW:0]   StepW     = (CW+1)'(StepLim);
   localparam logic [TW-1:0] TriesMax  = TW'(MAX_TRIES);
   localparam logic [PW-1:0] PipesLast = PW'(LEVEL_PIPES - 1);

   typedef enum logic [1:0] {StIdle, StDraw, StEmit} state_e;

   state_e          state_q, state_d;
   logic [7:0]      lfsr_q;
   logic [TW-1:0]   tries_q, tries_d;
   logic [CW-1:0]   gap_top_q, gap_top_d;
   logic [CW-1:0]   prev_top_q, prev_top_d;
   logic [CW-1:0]   gap_size_q, gap_size_d;
   logic [3:0]      level_q, level_d;
   logic [PW-1:0]   pipes_q, pipes_d;

   logic [CW-1:0]   cand, diff, fallback;
   logic [CW:0]     hi_w, cand_w, prev_w;
   logic            accept;

   // Free-running LFSR; deliberately untouched by restart so games differ.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= SEED;
      else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Candidate legality and step check; widened so ROWS-1-gap_size cannot wrap.
   always_comb begin
      cand   = lfsr_q[CW-1:0];
      cand_w = {1'b0, cand};
      prev_w = {1'b0, prev_top_q};
      hi_w   = RowsM1 - {1'b0, gap_size_q};
      diff   = (cand >= prev_top_q) ? (cand - prev_top_q) : (prev_top_q - cand);
      accept = (cand_w >= (CW+1)'(1)) && (cand_w <= hi_w) && ({1'b0, diff} <= StepW);
      if (prev_w < (CW+1)'(1))  fallback = CW'(1);
      else if (prev_w > hi_w)   fallback = hi_w[CW-1:0];
      else                      fallback = prev_top_q;
   end

   // Next-state: restart overrides everything; ack commits the column and difficulty.
   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      gap_top_d  = gap_top_q;
      prev_top_d = prev_top_q;
      gap_size_d = gap_size_q;
      level_d    = level_q;
      pipes_d    = pipes_q;
      if (restart_i) begin
         state_d    = StIdle;
         tries_d    = '0;
         gap_top_d  = TopInit;
         prev_top_d = TopInit;
         gap_size_d = GapInit;
         level_d    = '0;
         pipes_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_i) begin
                  state_d = StDraw;
                  tries_d = '0;
               end
            end
            StDraw: begin
               if (tries_q == TriesMax) begin
                  gap_top_d = fallback;
                  state_d   = StEmit;
               end else if (accept) begin
                  gap_top_d = cand;
                  state_d   = StEmit;
               end else begin
                  tries_d = tries_q + TW'(1);
               end
            end
            StEmit: begin
               if (col_ack_i) begin
                  state_d    = StIdle;
                  prev_top_d = gap_top_q;
                  if (pipes_q == PipesLast) begin
                     pipes_d = '0;
                     if (level_q != 4'hF)      level_d    = level_q + 4'd1;
                     if (gap_size_q != GapMin) gap_size_d = gap_size_q - CW'(1);
                  end else begin
                     pipes_d = pipes_q + PW'(1);
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         tries_q    <= '0;
         gap_top_q  <= TopInit;
         prev_top_q <= TopInit;
         gap_size_q <= GapInit;
         level_q    <= '0;
         pipes_q    <= '0;
      end else begin
         state_q    <= state_d;
         tries_q    <= tries_d;
         gap_top_q  <= gap_top_d;
         prev_top_q <= prev_top_d;
         gap_size_q <= gap_size_d;
         level_q    <= level_d;
         pipes_q    <= pipes_d;
      end
   end

   // Column pattern: pipe lit everywhere except the gap rows.
   always_comb begin
      col_o = '1;
      for (int i = 0; i < int'(ROWS); i++) begin
         if (i >= int'(gap_top_q) && i < int'(gap_top_q) + int'(gap_size_q)) col_o[i] = 1'b0;
      end
   end

   assign col_valid_o = (state_q == StEmit);
   assign busy_o      = (state_q != StIdle);
   assign gap_top_o   = gap_top_q;
   assign gap_size_o  = gap_size_q;
   assign level_o     = level_q;

endmodule

// File: tb/tb_pipe_column_gen.sv
// Directed + randomized bench for pipe_column_gen with a behavioural gap/difficulty model.
module tb_pipe_column_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        restart = 1'b0, req = 1'b0, col_ack = 1'b0;
   logic        col_valid, busy;
   logic [15:0] col;
   logic [3:0]  gap_top, gap_size, level;

   logic        req2 = 1'b0, ack2 = 1'b0;
   logic        valid2, busy2;
   logic [15:0] col2;
   logic [3:0]  top2, size2, level2;

   int n_tests = 0;
   int n_fail  = 0;
   int m_prev = 5, m_gs = 5, m_lvl = 0, m_cnt = 0;
   logic [7:0] m_lfsr;

   always #5 clk = ~clk;

   pipe_column_gen u_dut (
      .clk_i(clk), .rst_ni(rst_n), .restart_i(restart), .req_i(req), .col_ack_i(col_ack),
      .col_valid_o(col_valid), .col_o(col), .gap_top_o(gap_top), .gap_size_o(gap_size),
      .level_o(level), .busy_o(busy)
   );

   pipe_column_gen #(.MAX_STEP(0)) u_fb (
      .clk_i(clk), .rst_ni(rst_n), .restart_i(1'b0), .req_i(req2), .col_ack_i(ack2),
      .col_valid_o(valid2), .col_o(col2), .gap_top_o(top2), .gap_size_o(size2),
      .level_o(level2), .busy_o(busy2)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Reference LFSR value, advanced with the design's clock.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else        m_lfsr <= lfsr_next(m_lfsr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_col(input int top, input int gs);
      logic [15:0] c = '1;
      for (int i = 0; i < 16; i++) if (i >= top && i < top + gs) c[i] = 1'b0;
      return c;
   endfunction

   // Draw k (1-based) sees the LFSR k steps after the cycle req is raised.
   function automatic void predict(input logic [7:0] l0, input int prev, input int gs,
                                   input int ms, output int top, output int k);
      logic [7:0] l = l0;
      int c, d;
      bit found = 0;
      top = 0; k = 0;
      for (int i = 1; i <= 8; i++) begin
         l = lfsr_next(l);
         c = int'(l[3:0]);
         d = (c > prev) ? c - prev : prev - c;
         if (!found && c >= 1 && c + gs <= 15 && d <= ms) begin
            found = 1; top = c; k = i;
         end
      end
      if (!found) begin
         k = 9;
         if (prev < 1) top = 1;
         else if (prev > 15 - gs) top = 15 - gs;
         else top = prev;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_prev = 5; m_gs = 5; m_lvl = 0; m_cnt = 0;
   endtask

   task automatic do_col(input int delay, input bit hold);
      int et, ek, cyc, d;
      logic [15:0] c0;
      predict(m_lfsr, m_prev, m_gs, 3, et, ek);
      req = 1'b1;
      tick();
      if (!hold) req = 1'b0;
      cyc = 1;
      while (!col_valid && cyc < 12) begin
         tick();
         cyc++;
      end
      chk("latency", cyc, ek + 1);
      if (col_valid) begin
         d = (int'(gap_top) > m_prev) ? int'(gap_top) - m_prev : m_prev - int'(gap_top);
         chk("gap_top", gap_top, et);
         chk("col", col, exp_col(et, m_gs));
         chk("col_ends", {col[15], col[0]}, 2'b11);
         chk("step_ok", (d <= 3), 1);
         c0 = col;
         for (int i = 0; i < delay; i++) begin
            tick();
            chk("col_stable", {col_valid, col}, {1'b1, c0});
         end
         col_ack = 1'b1;
         req = 1'b0;
         tick();
         col_ack = 1'b0;
         chk("valid_drop", {col_valid, busy}, 2'b00);
         m_prev = et;
         m_cnt++;
         if (m_cnt == 8) begin
            m_cnt = 0;
            if (m_lvl < 15) m_lvl++;
            if (m_gs > 3) m_gs--;
         end
         chk("gap_size", gap_size, m_gs);
         chk("level", level, m_lvl);
         if (hold) begin
            tick();
            chk("no_second_col", busy, 0);
         end
      end else begin
         req = 1'b0;
      end
   endtask

   initial begin
      int cyc, found;
      logic [7:0] l;
      bit ok;

      // Reset values while held and after release
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {col_valid, busy}, 2'b00);
      chk("rst_gap_top", gap_top, 5);
      chk("rst_gap_size", gap_size, 5);
      chk("rst_level", level, 0);
      chk("rst_col", col, 16'hFC1F);
      rst_n = 1'b1;
      tick();
      chk("post_rst_col", col, 16'hFC1F);

      // Ack while idle does nothing
      col_ack = 1'b1;
      tick();
      tick();
      col_ack = 1'b0;
      chk("idle_ack_state", {col_valid, busy}, 2'b00);
      chk("idle_ack_top", gap_top, 5);
      chk("idle_ack_lvl", {level, gap_size}, {4'd0, 4'd5});

      // Difficulty ramp over 24 columns
      for (int i = 0; i < 24; i++) begin
         do_col($urandom_range(0, 5), 1'b0);
         if (i == 7)  chk("lvl1", {level, gap_size}, {4'd1, 4'd4});
         if (i == 15) chk("lvl2", {level, gap_size}, {4'd2, 4'd3});
         if (i == 23) chk("lvl3", {level, gap_size}, {4'd3, 4'd3});
      end

      // Same-cycle ack, then req held through EMIT
      do_col(0, 1'b0);
      do_col(3, 1'b1);

      // Restart mid-DRAW
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("draw_busy", busy, 1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      model_reset();
      chk("rs_draw_state", {col_valid, busy}, 2'b00);
      chk("rs_draw_vals", {gap_top, gap_size, level}, {4'd5, 4'd5, 4'd0});

      // Restart in EMIT together with ack
      req = 1'b1;
      tick();
      req = 1'b0;
      cyc = 0;
      while (!col_valid && cyc < 12) begin
         tick();
         cyc++;
      end
      chk("rs_emit_reached", col_valid, 1);
      restart = 1'b1;
      col_ack = 1'b1;
      tick();
      restart = 1'b0;
      col_ack = 1'b0;
      chk("rs_emit_state", {col_valid, busy}, 2'b00);
      chk("rs_emit_vals", {gap_top, gap_size, level}, {4'd5, 4'd5, 4'd0});
      // Counter must restart from zero: level steps only after 8 more acks
      for (int i = 0; i < 8; i++) begin
         do_col($urandom_range(0, 2), 1'b0);
         if (i == 6) chk("rs_cnt7", level, 0);
      end
      chk("rs_cnt8", level, 1);

      // Random sweep
      for (int i = 0; i < 200; i++) do_col($urandom_range(0, 5), 1'($urandom_range(0, 1)));

      // Asynchronous reset mid-EMIT
      req = 1'b1;
      tick();
      req = 1'b0;
      cyc = 0;
      while (!col_valid && cyc < 12) begin
         tick();
         cyc++;
      end
      chk("ar_emit_reached", col_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_state", {col_valid, busy}, 2'b00);
      chk("ar_vals", {gap_top, gap_size, level}, {4'd5, 4'd5, 4'd0});
      chk("ar_col", col, 16'hFC1F);
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();

      // Forced fallback on the MAX_STEP=0 instance: pick a window with no draw of 5
      found = 0;
      for (int t = 0; t < 300 && found == 0; t++) begin
         l = m_lfsr;
         ok = 1'b1;
         for (int k = 0; k < 8; k++) begin
            l = lfsr_next(l);
            if (l[3:0] == 4'd5) ok = 1'b0;
         end
         if (ok) found = 1;
         else tick();
      end
      if (found == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL fb_window: observed none expected a draw window");
      end else begin
         req2 = 1'b1;
         tick();
         req2 = 1'b0;
         cyc = 1;
         while (!valid2 && cyc < 14) begin
            tick();
            cyc++;
         end
         chk("fb_latency", cyc, 10);
         chk("fb_gap_top", top2, 5);
         chk("fb_col", col2, 16'hFC1F);
         ack2 = 1'b1;
         tick();
         ack2 = 1'b0;
         chk("fb_drop", {valid2, busy2}, 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_column_gen.md
# pipe_column_gen

Sequential, parametrised pipe-column generator for the LED playfield. It owns an 8-bit LFSR and produces one pipe column per request over a valid/ack handshake. Successive gap positions are kept within a reachable vertical step of each other. The gap shrinks as the player clears pipes. It sits between the game controller, which requests a column each time the scroll logic frees the rightmost column, and the playfield shift register, which loads `col` on ack.

## Interface

Parameters:
- `ROWS`, 16: column height in LEDs. Range 8..32.
- `GAP_INIT`, 5: gap height after reset or restart.
- `GAP_MIN`, 3: smallest gap height. Requires 1 ≤ GAP_MIN ≤ GAP_INIT ≤ ROWS-2.
- `MAX_STEP`, 3: maximum |gap_top - previous gap_top| between consecutive columns.
- `LEVEL_PIPES`, 8: number of acked columns per difficulty step.
- `MAX_TRIES`, 8: number of LFSR draws before the fallback is used.
- `SEED`, 8'hA5: LFSR reset value. Must be non-zero.

Ports (CW = $clog2(ROWS)):
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `restart`, in, 1: synchronous new-game clear.
- `req`, in, 1: request a new column. Sampled only in IDLE.
- `col_ack`, in, 1: consumer accepts `col`.
- `col_valid`, out, 1: `col` holds a new column.
- `col`, out, ROWS: column pattern. Bit i = 1 means pipe LED lit. Bit 0 is the top row.
- `gap_top`, out, CW: first gap row of the current/last column.
- `gap_size`, out, CW: current gap height.
- `level`, out, 4: difficulty level, saturating at 15.
- `busy`, out, 1: FSM is not in IDLE.

## Operation

- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts left every cycle while `reset_n` is high. The new bit 0 is `l[7]^l[5]^l[4]^l[3]`. It is not affected by `restart`.
- Legal gap rows: `gap_top` must lie in 1..ROWS-1-gap_size, so at least one pipe row remains at each end.
- FSM states: IDLE, DRAW, EMIT.
  - IDLE → DRAW when `req`=1. The try counter is cleared.
  - DRAW: each cycle the candidate is `lfsr[CW-1:0]`. It is accepted when it is legal and |cand - prev_top| ≤ MAX_STEP. On accept, latch `gap_top` = cand and go to EMIT.
  - DRAW after MAX_TRIES rejections: `gap_top` = prev_top clamped into the legal range, then go to EMIT.
  - EMIT: `col_valid`=1. The column is held stable until `col_ack`=1, then go to IDLE.
- Column build (combinational from `gap_top` and `gap_size`): bits `gap_top` .. `gap_top+gap_size-1` are 0, all other bits are 1.
- On the ack cycle:
  - prev_top ← gap_top.
  - The pipe counter increments.
  - When the counter reaches LEVEL_PIPES, it clears, `level` increments (saturating), and `gap_size` decrements unless it is already GAP_MIN.
  - The new `gap_size` applies to the next column only. The accepted column is unaffected.
- Width rules:
  - Differences are computed unsigned as the larger value minus the smaller one.
  - Range checks are done at CW+1 bits, so ROWS-1-gap_size cannot wrap.
- `restart`, in any state, takes effect on the next edge:
  - FSM → IDLE and `col_valid` → 0.
  - `gap_size` → GAP_INIT, `level` → 0, pipe counter → 0.
  - prev_top and `gap_top` → (ROWS-GAP_INIT)/2.
  - `restart` has priority over `req` and `col_ack` in the same cycle.
- `req` outside IDLE is ignored and not queued. `col_ack` without `col_valid` is ignored.

## Timing

- Reset values:
  - FSM = IDLE; `col_valid` = 0; `busy` = 0.
  - `gap_top` = (ROWS-GAP_INIT)/2; `gap_size` = GAP_INIT; `level` = 0.
  - LFSR = SEED.
  - `col` reflects the reset `gap_top`/`gap_size`: 16'hFC1F at the defaults.
- Latency: `req` high in IDLE at edge n puts the FSM in DRAW at n+1. Acceptance on the k-th draw (k = 1..MAX_TRIES) gives `col_valid`=1 after edge n+1+k.
  - Best case: 2 cycles.
  - Fallback: MAX_TRIES+2 cycles.
- `col_ack` in the first `col_valid` cycle is legal. In that case `col_valid` is high for exactly one cycle.
- `busy` is registered with the state: high in DRAW and EMIT.
- An asynchronous `reset_n` assertion mid-DRAW or mid-EMIT forces all reset values immediately. No column is emitted.

## Test plan

- Reset, defaults: hold `reset_n`=0, then release. `col_valid`=0, `gap_top`=5, `gap_size`=5, `level`=0, `col`=16'hFC1F.
- Forced fallback, MAX_STEP=0 and SEED chosen so that no draw equals 5: `req` pulse gives `col_valid` exactly 10 cycles later with `gap_top`=5 and `col`=16'hFC1F.
- Random sweep, defaults: 200 requests with random ack delay of 0–5 cycles. For every column:
  - exactly `gap_size` zero bits, and they are contiguous;
  - bits 0 and 15 are 1;
  - |Δgap_top| ≤ 3;
  - `col` is stable while valid.
- Difficulty: 16 acked columns. After the 8th ack `gap_size`=4 and `level`=1. After the 16th ack `gap_size`=3 and `level`=2. With 8 further acks `gap_size` stays 3 and `level`=3.
- Handshake edges:
  - `req` held high during EMIT causes no second column.
  - Same-cycle `col_ack` gives a 1-cycle valid.
  - `col_ack` while IDLE changes nothing.
- Restart: assert `restart` mid-DRAW and then in EMIT together with `col_ack`. Next cycle: IDLE, `col_valid`=0, `gap_size`=5, `level`=0, `gap_top`=5, pipe counter not incremented.
